// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter, LSB first.
// Built-in baud divider plus one-entry holding register for gapless streaming.
module uart_tx #(
  parameter int BAUDRATE  = 104,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       busy,
  output logic       tx
);

  localparam int CW = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(BAUDRATE - 1);
  localparam logic [2:0] SLAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nx;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nx;
  logic [7:0]    r_hold;
  logic          r_full;
  logic          w_full_nx;
  logic          r_tx;
  logic          w_tx_nx;
  logic          w_accept;
  logic          w_load;
  logic          w_tick;

  assign w_accept = start && !r_full;
  assign w_tick   = (r_cnt == CMAX);
  assign ready    = !r_full;
  assign busy     = (r_state != S_IDLE) || r_full;
  assign tx       = r_tx;

  // Engine next state, counters, shifter and line level.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = w_tick ? '0 : r_cnt + 1'b1;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_load     = 1'b0;
    w_tx_nx    = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (r_full) begin
          w_load     = 1'b1;
          w_shift_nx = r_hold;
          w_state_nx = S_START;
        end
      end
      S_START: begin
        w_tx_nx = 1'b0;
        if (w_tick) begin
          w_state_nx = S_DATA;
          w_idx_nx   = '0;
        end
      end
      S_DATA: begin
        w_tx_nx = r_shift[0];
        if (w_tick) begin
          w_shift_nx = r_shift >> 1;
          w_idx_nx   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
            w_state_nx = S_STOP;
            w_idx_nx   = '0;
          end
        end
      end
      S_STOP: begin
        if (w_tick) begin
          if (r_idx == SLAST) begin
            w_idx_nx = '0;
            if (r_full) begin
              w_load     = 1'b1;
              w_shift_nx = r_hold;
              w_state_nx = S_START;
            end else begin
              w_state_nx = S_IDLE;
            end
          end else begin
            w_idx_nx = r_idx + 3'd1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Engine emptying wins over a new request; ready was low anyway.
  always_comb begin
    w_full_nx = r_full;
    if (w_load) begin
      w_full_nx = 1'b0;
    end else if (w_accept) begin
      w_full_nx = 1'b1;
    end
  end

  // State, holding register and registered tx line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_hold  <= '0;
      r_full  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
      r_full  <= w_full_nx;
      r_tx    <= w_tx_nx;
      if (w_accept) begin
        r_hold <= data;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench with byte scoreboard and serial line monitor.
// Unit 0 runs 1 stop bit, unit 1 runs 2 stop bits, both at 4 clocks/bit.
module tb_uart_tx;

  localparam int BR = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic [7:0] data1 = 8'h00;
  logic       ready0, busy0, tx0;
  logic       ready1, busy1, tx1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         done[2];
  int         last_fall[2];
  int         prev_fall[2];
  int         mpos[2];
  logic       mact[2];
  logic [7:0] mexp[2];

  uart_tx #(.BAUDRATE(BR), .STOP_BITS(1)) u0 (
    .clk(clk), .rstn(rstn), .start(start0), .data(data0),
    .ready(ready0), .busy(busy0), .tx(tx0)
  );

  uart_tx #(.BAUDRATE(BR), .STOP_BITS(2)) u1 (
    .clk(clk), .rstn(rstn), .start(start1), .data(data1),
    .ready(ready1), .busy(busy1), .tx(tx1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Line monitor: decodes frames and checks every sampled bit cycle.
  task automatic mon(int u, logic t, int sb);
    int   k;
    int   qs;
    logic e;
    if (!rstn) begin
      mact[u] = 1'b0;
      return;
    end
    if (!mact[u] && t === 1'b0) begin
      qs = (u == 0) ? q0.size() : q1.size();
      chk1($sformatf("u%0d_frame_expected", u), qs > 0, 1'b1);
      if (qs > 0) mexp[u] = (u == 0) ? q0.pop_front() : q1.pop_front();
      else        mexp[u] = 8'h00;
      mact[u] = 1'b1;
      mpos[u] = 0;
      prev_fall[u] = last_fall[u];
      last_fall[u] = cyc;
    end
    if (mact[u]) begin
      k = mpos[u] / BR;
      if (k == 0)      e = 1'b0;
      else if (k <= 8) e = mexp[u][k-1];
      else             e = 1'b1;
      chk1($sformatf("u%0d_byte%02h_bit%0d", u, mexp[u], k), t, e);
      mpos[u]++;
      if (mpos[u] == BR * (9 + sb)) begin
        mact[u] = 1'b0;
        done[u]++;
      end
    end
  endtask

  always @(negedge clk) mon(0, tx0, 1);
  always @(negedge clk) mon(1, tx1, 2);

  function automatic logic rdy(int u);
    return (u == 0) ? ready0 : ready1;
  endfunction

  task automatic send(int u, logic [7:0] b, output int acc);
    int n = 0;
    while (rdy(u) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1($sformatf("u%0d_ready_before_send", u), rdy(u), 1'b1);
    if (u == 0) begin start0 = 1'b1; data0 = b; end
    else        begin start1 = 1'b1; data1 = b; end
    acc = cyc + 1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    data0 = 8'hxx;
    data1 = 8'hxx;
    if (u == 0) q0.push_back(b);
    else        q1.push_back(b);
    @(negedge clk);
  endtask

  task automatic wait_done(int u, int target);
    int n = 0;
    while (done[u] < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chkn($sformatf("u%0d_frames_done", u), done[u], target);
  endtask

  task automatic wait_cyc(int target);
    int n = 0;
    while (cyc < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chkn("wait_cycle", cyc, target);
  endtask

  task automatic wait_act(int u);
    int n = 0;
    while (!mact[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1($sformatf("u%0d_frame_started", u), mact[u], 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int b;
    int f;
    for (int i = 0; i < 2; i++) begin
      done[i] = 0;
      last_fall[i] = 0;
      prev_fall[i] = 0;
      mpos[i] = 0;
      mact[i] = 1'b0;
      mexp[i] = 8'h00;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk1("rst_tx0", tx0, 1'b1);
    chk1("rst_ready0", ready0, 1'b1);
    chk1("rst_busy0", busy0, 1'b0);
    chk1("rst_tx1", tx1, 1'b1);
    chk1("rst_busy1", busy1, 1'b0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    chk1("idle_tx0", tx0, 1'b1);

    // Single byte 0x55: latency, ready recovery, busy window.
    send(0, 8'h55, a);
    chk1("t1_ready_low", ready0, 1'b0);
    @(negedge clk);
    chk1("t1_ready_back", ready0, 1'b1);
    chk1("t1_busy", busy0, 1'b1);
    wait_act(0);
    f = last_fall[0];
    chkn("t1_fall_latency", f - a, 2);
    wait_cyc(f + 38);
    chk1("t1_busy_in_stop", busy0, 1'b1);
    wait_cyc(f + 40);
    chk1("t1_busy_dropped", busy0, 1'b0);
    wait_done(0, 1);

    // LSB-first order.
    send(0, 8'hA3, a);
    chk1("t2_ready_low", ready0, 1'b0);
    @(negedge clk);
    chk1("t2_ready_back", ready0, 1'b1);
    wait_done(0, 2);

    // Back-to-back: no idle gap between frames.
    send(0, 8'h00, a);
    send(0, 8'hFF, b);
    chkn("t3_second_accept", b - a, 2);
    wait_done(0, 4);
    chkn("t3_frame_spacing", last_fall[0] - prev_fall[0], 40);
    chk1("t3_idle_after", busy0, 1'b0);

    // Start while holding register full is ignored.
    send(0, 8'h11, a);
    send(0, 8'h22, b);
    chk1("t4_hold_full", ready0, 1'b0);
    start0 = 1'b1;
    data0 = 8'h12;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    data0 = 8'h00;
    @(negedge clk);
    chk1("t4_still_full", ready0, 1'b0);
    wait_done(0, 6);
    repeat (60) @(negedge clk);
    chkn("t4_no_extra_frame", done[0], 6);
    chkn("t4_queue_empty", q0.size(), 0);
    chk1("t4_line_idle", tx0, 1'b1);

    // Reset during data bit 3 of 0xF0.
    send(0, 8'hF0, a);
    wait_act(0);
    f = last_fall[0];
    wait_cyc(f + 4 * BR + 1);
    chk1("t5_bit3_low", tx0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk1("t5_rst_tx", tx0, 1'b1);
    chk1("t5_rst_ready", ready0, 1'b1);
    chk1("t5_rst_busy", busy0, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk1("t5_tx_idle", tx0, 1'b1);
    send(0, 8'h3C, a);
    wait_done(0, 7);

    // Two stop bits, two queued bytes.
    send(1, 8'h81, a);
    send(1, 8'h7E, b);
    wait_done(1, 2);
    chkn("t6_frame_spacing", last_fall[1] - prev_fall[1], 44);
    repeat (4) @(negedge clk);
    chk1("t6_busy_done", busy1, 1'b0);

    chkn("final_q0_empty", q0.size(), 0);
    chkn("final_q1_empty", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
